// File: rtl/rib_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rib_arbiter
// Description : Four-master arbiter for the core's internal bus. It issues a
//               registered one-hot grant with fixed priority m0 > m1 and
//               round-robin between m2/m3. It also handles burst fairness,
//               ack timeout and the pipeline bus-hold flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rib_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 256
) (
    input  logic       clk,
    input  logic       rst,          // asynchronous, active-low
    input  logic [3:0] req_i,
    input  logic       ack_i,
    output logic [3:0] gnt_o,
    output logic [1:0] gnt_id_o,
    output logic       gnt_valid_o,
    output logic       hold_flag_o,
    output logic       err_o
);

    localparam int c_BW = $clog2(MAX_BURST + 1);
    localparam int c_TW = $clog2(TIMEOUT);
    localparam logic [c_BW-1:0] c_BURST_MAX = c_BW'(MAX_BURST);
    localparam logic [c_TW-1:0] c_TMO_LAST  = c_TW'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    logic [3:0]      r_gnt;
    logic [1:0]      r_gnt_id;
    logic            r_gnt_valid;
    logic            r_hold;
    logic            r_err;
    logic            r_rr_last;      // 1: m3 was the last m2/m3 winner, 0: m2
    logic [c_BW-1:0] r_burst;
    logic [c_TW-1:0] r_tmo;

    logic [3:0]      w_other_req;
    logic            w_own_req;
    logic [c_BW-1:0] w_burst_next;
    logic            w_keep;
    logic [2:0]      w_pick_all;
    logic [2:0]      w_pick_other;
    logic            w_sw_valid;
    logic [1:0]      w_sw_id;
    logic            w_do_switch;
    logic            w_do_timeout;

    // Winner among a request vector: {valid, id}. m0 > m1 > {m2,m3}; a tie
    // between m2 and m3 goes to the one that did not win last time.
    function automatic logic [2:0] f_pick(input logic [3:0] req, input logic rr_last);
        logic [2:0] res;
        res = 3'b000;
        if (req[0])                   res = {1'b1, 2'd0};
        else if (req[1])              res = {1'b1, 2'd1};
        else if (req[2] && req[3])    res = rr_last ? {1'b1, 2'd2} : {1'b1, 2'd3};
        else if (req[2])              res = {1'b1, 2'd2};
        else if (req[3])              res = {1'b1, 2'd3};
        return res;
    endfunction

    // Decode the arbitration event for this cycle from registered state and inputs.
    always_comb begin
        w_other_req  = req_i & ~r_gnt;
        w_own_req    = |(req_i & r_gnt);
        w_burst_next = r_burst + 1'b1;
        w_keep       = w_own_req && ((w_burst_next < c_BURST_MAX) || !(|w_other_req));
        w_pick_all   = f_pick(req_i, r_rr_last);
        w_pick_other = f_pick(w_other_req, r_rr_last);
        // From IDLE everyone competes; a switch while busy excludes the holder.
        w_sw_valid   = (r_state == ST_IDLE) ? w_pick_all[2]   : w_pick_other[2];
        w_sw_id      = (r_state == ST_IDLE) ? w_pick_all[1:0] : w_pick_other[1:0];
        w_do_switch  = (r_state == ST_IDLE) ||
                       (ack_i && !w_keep) ||
                       (!ack_i && !w_own_req);
        // An ack in the same cycle takes precedence over the timeout.
        w_do_timeout = (r_state == ST_BUSY) && !ack_i && w_own_req && (r_tmo == c_TMO_LAST);
    end

    // Grant FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_gnt       <= 4'b0000;
            r_gnt_id    <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_hold      <= 1'b0;
            r_err       <= 1'b0;
            r_rr_last   <= 1'b1;
            r_burst     <= '0;
            r_tmo       <= '0;
        end else begin
            r_err <= 1'b0;
            if (w_do_switch) begin
                r_burst <= '0;
                r_tmo   <= '0;
                if (w_sw_valid) begin
                    r_state     <= ST_BUSY;
                    r_gnt       <= 4'b0001 << w_sw_id;
                    r_gnt_id    <= w_sw_id;
                    r_gnt_valid <= 1'b1;
                    r_hold      <= (w_sw_id != 2'd3);
                    if (w_sw_id[1]) begin
                        r_rr_last <= w_sw_id[0];
                    end
                end else begin
                    r_state     <= ST_IDLE;
                    r_gnt       <= 4'b0000;
                    r_gnt_id    <= 2'd0;
                    r_gnt_valid <= 1'b0;
                    r_hold      <= 1'b0;
                end
            end else if (w_do_timeout) begin
                // Forced release drops to IDLE for one cycle; the released
                // master competes again from IDLE like everyone else.
                r_state     <= ST_IDLE;
                r_gnt       <= 4'b0000;
                r_gnt_id    <= 2'd0;
                r_gnt_valid <= 1'b0;
                r_hold      <= 1'b0;
                r_err       <= 1'b1;
                r_burst     <= '0;
                r_tmo       <= '0;
            end else if (ack_i) begin
                // Keeping the grant: a burst that hits the limit uncontended restarts.
                r_burst <= (w_burst_next == c_BURST_MAX) ? '0 : w_burst_next;
                r_tmo   <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    assign gnt_o       = r_gnt;
    assign gnt_id_o    = r_gnt_id;
    assign gnt_valid_o = r_gnt_valid;
    assign hold_flag_o = r_hold;
    assign err_o       = r_err;

endmodule
`default_nettype wire
